gpio_ctrl: RTL and testbench
============================

GPIO_CTRL -- requirements
Module: gpio_ctrl

Interface
REQ-001 Parameter GPIO_W, default 8, number of GPIO pins; legal range 1..32.
REQ-002 Parameter IRQ_EDGE, default 1, interrupt edge select: 1 = rising, 0 = falling.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 rstn  input  1  asynchronous, active-low reset.
REQ-005 sel  input  1  peripheral select, decoded externally from the upper address bits.
REQ-006 addr  input  5  byte offset; bits [4:2] select the register, bits [1:0] are ignored.
REQ-007 datamem_wr  input  4  per-byte write enables; bit k writes byte lane k.
REQ-008 data_wr0..data_wr3  input  8 each  write data byte lanes 0..3, lane 0 = bits [7:0].
REQ-009 data_rd  output  32  registered read data.
REQ-010 gpio_i  input  GPIO_W  asynchronous pin inputs.
REQ-011 gpio_o  output  GPIO_W  pin output values.
REQ-012 gpio_oe  output  GPIO_W  per-pin output enable; 1 = drive.
REQ-013 irq  output  1  level interrupt request.

Function
REQ-014 Register map, by addr[4:2]:
- 0 OUT: read/write.
- 1 DIR: read/write.
- 2 IN: read-only.
- 3 SET: write 1s to set OUT bits.
- 4 CLR: write 1s to clear OUT bits.
- 5 TGL: write 1s to invert OUT bits.
- 6 IE: read/write interrupt enable.
- 7 IS: interrupt status, write-1-to-clear.
REQ-015 Write condition: sel=1 and datamem_wr[k]=1 writes byte lane k only; the other lanes are unchanged.
REQ-016 Width rule: register bits at or above GPIO_W are not stored, ignore writes, and read as 0.
REQ-017 SET, CLR and TGL read as 0.
REQ-018 SET/CLR/TGL update OUT on the clock edge of the write; OUT is visible on gpio_o the next cycle.
REQ-019 gpio_o = OUT and gpio_oe = DIR, both driven directly from flops.
REQ-020 Input synchronisation: gpio_i passes through a two-flop synchroniser; IN = second stage. Latency from pin change to IN is 2 cycles.
REQ-021 Read: data_rd is loaded on every clock edge with sel=1 and datamem_wr=0, from the register at addr; otherwise data_rd loads 0. Read latency is 1 cycle.
REQ-022 Read during write: sel=1 with datamem_wr!=0 loads data_rd with 0.
REQ-023 Edge detect: a third flop holds the previous IN value. An edge event on bit i sets IS[i] one cycle after IN[i] changes in the IRQ_EDGE direction.
REQ-024 Simultaneous edge event and W1C on the same IS bit in the same cycle: the set wins.
REQ-025 irq = OR over i of (IS[i] & IE[i]), registered, 1-cycle latency.
REQ-026 IS bits latch regardless of the IE setting.
REQ-027 Pins configured as outputs (DIR=1) are still sampled into IN and still generate events.
REQ-028 sel=0: no register changes except the synchroniser, edge-detect and IS set logic.

Reset
REQ-029 rstn=0 immediately clears OUT, DIR, IE, IS, all synchroniser and edge flops, data_rd and irq.
REQ-030 Reset outputs: gpio_o=0, gpio_oe=0, irq=0, data_rd=0.
REQ-031 A write in progress when reset asserts is discarded.
REQ-032 No edge event is generated on the first cycles after reset release unless the synchronised input rises from its reset value of 0.

Configuration
REQ-033 Macro GPIO_IRQ_EN defined: IE, IS, the edge-detect flop and irq are implemented per REQ-023..REQ-027.
REQ-034 Macro GPIO_IRQ_EN undefined: that logic is not compiled; offsets 6 and 7 ignore writes and read 0; irq is tied 0.

Verification
REQ-035 Reset release, then read offsets 0..7 -> all data_rd=0x00000000; gpio_o=0, gpio_oe=0.
REQ-036 GPIO_W=8. Write OUT=0xFFFFFFA5 with datamem_wr=4'b1111, then write SET=0x0A, CLR=0x01, TGL=0xF0 -> gpio_o sequence 0xA5, 0xAF, 0xAE, 0x5E; OUT reads 0x0000005E.
REQ-037 GPIO_W=16. Write DIR=0x1234 with datamem_wr=4'b0010 -> DIR reads 0x1200, gpio_oe=0x1200.
REQ-038 gpio_i[3] rises at cycle t -> IN[3] reads 1 from t+2; IS=0x08 at t+3. With IE=0x08, irq=1 at t+4. W1C IS=0x08 -> irq=0 two cycles later.
REQ-039 Edge event on bit 0 coinciding with W1C of IS bit 0 -> IS[0] remains 1.
REQ-040 Build without GPIO_IRQ_EN; toggle all inputs -> irq stays 0; offsets 6 and 7 read 0 after writing 0xFF.

Source files
------------

// File: rtl/gpio_ctrl.sv
// -----------------------------------------------------------------------------
// gpio_ctrl -- memory-mapped GPIO block with optional edge interrupts.
//
// Optional feature macro: GPIO_IRQ_EN
//   defined   : IE / IS registers, edge-detect flop and the irq output exist.
//   undefined : offsets 6 and 7 ignore writes and read 0, irq is tied to 0.
//
// Ports
//   clk                 system clock, rising edge
//   rstn                asynchronous active-low reset
//   sel                 peripheral select
//   addr[4:0]           byte offset, addr[4:2] picks the register
//   datamem_wr[3:0]     per-byte-lane write enables
//   data_wr0..data_wr3  write data lanes 0..3 (lane 0 = bits [7:0])
//   data_rd[31:0]       registered read data, 1-cycle latency
//   gpio_i              asynchronous pin inputs
//   gpio_o / gpio_oe    pin output values / output enables (1 = drive)
//   irq                 level interrupt request
//
// Bus handshake: there is no valid/ready pair. A cycle with sel=1 and
// datamem_wr!=0 is a write that takes effect on that clock edge; a cycle with
// sel=1 and datamem_wr=0 is a read whose data appears on data_rd after that
// edge. Every other cycle loads data_rd with 0.
//
// Register map (addr[4:2]): 0 OUT, 1 DIR, 2 IN (ro), 3 SET, 4 CLR, 5 TGL,
// 6 IE, 7 IS (write-1-to-clear). Bits at or above GPIO_W read as 0.
// -----------------------------------------------------------------------------
module gpio_ctrl #(
  parameter int GPIO_W   = 8,
  parameter int IRQ_EDGE = 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              sel,
  input  logic [4:0]        addr,
  input  logic [3:0]        datamem_wr,
  input  logic [7:0]        data_wr0,
  input  logic [7:0]        data_wr1,
  input  logic [7:0]        data_wr2,
  input  logic [7:0]        data_wr3,
  output logic [31:0]       data_rd,
  input  logic [GPIO_W-1:0] gpio_i,
  output logic [GPIO_W-1:0] gpio_o,
  output logic [GPIO_W-1:0] gpio_oe,
  output logic              irq
);

  localparam logic [2:0] REG_OUT = 3'd0;
  localparam logic [2:0] REG_DIR = 3'd1;
  localparam logic [2:0] REG_IN  = 3'd2;
  localparam logic [2:0] REG_SET = 3'd3;
  localparam logic [2:0] REG_CLR = 3'd4;
  localparam logic [2:0] REG_TGL = 3'd5;
  localparam logic [2:0] REG_IE  = 3'd6;
  localparam logic [2:0] REG_IS  = 3'd7;

  // Byte-lane decode, then truncation to the implemented pin width.
  logic [31:0]       wdata;
  logic [31:0]       wmask;
  logic [31:0]       wgated;
  logic [GPIO_W-1:0] wbits;
  logic [GPIO_W-1:0] wm;
  logic              wr_en;
  logic              rd_en;
  logic [2:0]        reg_sel;

  assign wdata   = {data_wr3, data_wr2, data_wr1, data_wr0};
  assign wmask   = {{8{datamem_wr[3]}}, {8{datamem_wr[2]}},
                    {8{datamem_wr[1]}}, {8{datamem_wr[0]}}};
  assign wgated  = wdata & wmask;
  assign wbits   = wgated[GPIO_W-1:0];
  assign wm      = wmask[GPIO_W-1:0];
  assign wr_en   = sel & (|datamem_wr);
  assign rd_en   = sel & ~(|datamem_wr);
  assign reg_sel = addr[4:2];

  // Bits above GPIO_W and addr[1:0] are intentionally discarded.
  logic unused_bits;
  assign unused_bits = (^{wgated, wmask, addr[1:0]}) ^ (IRQ_EDGE != 0);

  logic [GPIO_W-1:0] out_q, out_d;
  logic [GPIO_W-1:0] dir_q, dir_d;
  logic [GPIO_W-1:0] sync1_q;
  logic [GPIO_W-1:0] in_q;        // second synchroniser stage = IN register
  logic [31:0]       data_rd_q, data_rd_d;
  logic [31:0]       rd_val;

`ifdef GPIO_IRQ_EN
  logic [GPIO_W-1:0] prev_q;      // IN one cycle ago, for edge detection
  logic [GPIO_W-1:0] ie_q, ie_d;
  logic [GPIO_W-1:0] is_q, is_d;
  logic [GPIO_W-1:0] edge_ev;
  logic              irq_q;

  assign edge_ev = (IRQ_EDGE != 0) ? (in_q & ~prev_q) : (~in_q & prev_q);

  always_comb begin
    ie_d = ie_q;
    is_d = is_q;
    if (wr_en && reg_sel == REG_IE) ie_d = (ie_q & ~wm) | wbits;
    if (wr_en && reg_sel == REG_IS) is_d = is_q & ~wbits;
    // OR-ing the event in last makes a same-cycle set win over the clear.
    is_d = is_d | edge_ev;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      prev_q <= '0;
      ie_q   <= '0;
      is_q   <= '0;
      irq_q  <= 1'b0;
    end else begin
      prev_q <= in_q;
      ie_q   <= ie_d;
      is_q   <= is_d;
      irq_q  <= |(is_q & ie_q);
    end
  end

  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

  always_comb begin
    out_d = out_q;
    dir_d = dir_q;
    if (wr_en) begin
      case (reg_sel)
        REG_OUT: out_d = (out_q & ~wm) | wbits;
        REG_DIR: dir_d = (dir_q & ~wm) | wbits;
        REG_SET: out_d = out_q | wbits;
        REG_CLR: out_d = out_q & ~wbits;
        REG_TGL: out_d = out_q ^ wbits;
        default: ;
      endcase
    end
  end

  always_comb begin
    rd_val = '0;
    case (reg_sel)
      REG_OUT: rd_val[GPIO_W-1:0] = out_q;
      REG_DIR: rd_val[GPIO_W-1:0] = dir_q;
      REG_IN:  rd_val[GPIO_W-1:0] = in_q;
`ifdef GPIO_IRQ_EN
      REG_IE:  rd_val[GPIO_W-1:0] = ie_q;
      REG_IS:  rd_val[GPIO_W-1:0] = is_q;
`endif
      default: rd_val = '0;
    endcase
    data_rd_d = rd_en ? rd_val : '0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_q     <= '0;
      dir_q     <= '0;
      sync1_q   <= '0;
      in_q      <= '0;
      data_rd_q <= '0;
    end else begin
      out_q     <= out_d;
      dir_q     <= dir_d;
      sync1_q   <= gpio_i;
      in_q      <= sync1_q;
      data_rd_q <= data_rd_d;
    end
  end

  assign data_rd = data_rd_q;
  assign gpio_o  = out_q;
  assign gpio_oe = dir_q;

endmodule

// File: tb/tb_gpio_ctrl.sv
// -----------------------------------------------------------------------------
// tb_gpio_ctrl -- drives two gpio_ctrl instances from one shared bus:
//   u_dut8  : GPIO_W=8,  rising-edge interrupts
//   u_dut16 : GPIO_W=16, falling-edge interrupts
// A behavioural model tracks both; a vector table and short hand-written
// sequences carry explicit expected values for the documented scenarios.
// -----------------------------------------------------------------------------
module tb_gpio_ctrl;

`ifdef GPIO_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  // ---------------- clock / reset / DUTs ----------------
  logic        clk = 1'b0;
  logic        rstn;
  logic        sel;
  logic [4:0]  addr;
  logic [3:0]  dm;
  logic [31:0] wd;
  logic [15:0] pins;

  logic [31:0] rd8, rd16;
  logic [7:0]  o8, oe8;
  logic [15:0] o16, oe16;
  logic        irq8, irq16;

  always #5 clk = ~clk;

  gpio_ctrl #(.GPIO_W(8), .IRQ_EDGE(1)) u_dut8 (
    .clk(clk), .rstn(rstn), .sel(sel), .addr(addr), .datamem_wr(dm),
    .data_wr0(wd[7:0]), .data_wr1(wd[15:8]), .data_wr2(wd[23:16]), .data_wr3(wd[31:24]),
    .data_rd(rd8), .gpio_i(pins[7:0]), .gpio_o(o8), .gpio_oe(oe8), .irq(irq8)
  );

  gpio_ctrl #(.GPIO_W(16), .IRQ_EDGE(0)) u_dut16 (
    .clk(clk), .rstn(rstn), .sel(sel), .addr(addr), .datamem_wr(dm),
    .data_wr0(wd[7:0]), .data_wr1(wd[15:8]), .data_wr2(wd[23:16]), .data_wr3(wd[31:24]),
    .data_rd(rd16), .gpio_i(pins), .gpio_o(o16), .gpio_oe(oe16), .irq(irq16)
  );

  // ---------------- scoreboard counters ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Registers per instance, kept as plain 32-bit words masked to the width.
  localparam logic [31:0] MASK [2] = '{32'h0000_00FF, 32'h0000_FFFF};
  localparam bit          RISE [2] = '{1'b1, 1'b0};

  logic [31:0] m_out [2];
  logic [31:0] m_dir [2];
  logic [31:0] m_ie  [2];
  logic [31:0] m_is  [2];
  logic [31:0] m_rd  [2];
  logic        m_irq [2];
  // Pin history: IN equals the pins sampled two edges ago.
  logic [31:0] pin_line [$];
  logic [31:0] m_in;
  logic [31:0] m_in_old;

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_out[k] = '0; m_dir[k] = '0; m_ie[k] = '0; m_is[k] = '0;
      m_rd[k]  = '0; m_irq[k] = 1'b0;
    end
    pin_line.delete();
    pin_line.push_back('0);
    m_in     = '0;
    m_in_old = '0;
  endtask

  // Applies the effect of one rising edge, using the values just before it.
  task automatic model_edge();
    logic [31:0] bm, wv, mk, rv, ev;
    int r;
    bm = {{8{dm[3]}}, {8{dm[2]}}, {8{dm[1]}}, {8{dm[0]}}};
    r  = int'(addr) / 4;
    for (int k = 0; k < 2; k++) begin
      mk = MASK[k];
      wv = wd & bm & mk;
      case (r)
        0: rv = m_out[k];
        1: rv = m_dir[k];
        2: rv = m_in & mk;
        6: rv = m_ie[k];
        7: rv = m_is[k];
        default: rv = '0;
      endcase
      m_irq[k] = IRQ_EN && ((m_is[k] & m_ie[k]) != 0);
      m_rd[k]  = (sel && dm == 4'd0) ? rv : 32'd0;
      ev = '0;
      if (IRQ_EN) ev = (RISE[k] ? (m_in & ~m_in_old) : (~m_in & m_in_old)) & mk;
      if (sel && dm != 4'd0) begin
        case (r)
          0: m_out[k] = (m_out[k] & ~(bm & mk)) | wv;
          1: m_dir[k] = (m_dir[k] & ~(bm & mk)) | wv;
          3: m_out[k] = m_out[k] | wv;
          4: m_out[k] = m_out[k] & ~wv;
          5: m_out[k] = m_out[k] ^ wv;
          6: if (IRQ_EN) m_ie[k] = (m_ie[k] & ~(bm & mk)) | wv;
          7: if (IRQ_EN) m_is[k] = m_is[k] & ~wv;
          default: ;
        endcase
      end
      m_is[k] = m_is[k] | ev;
    end
    m_in_old = m_in;
    m_in     = pin_line.pop_front();
    pin_line.push_back({16'h0, pins});
  endtask

  task automatic model_check();
    check("m8_rd",   rd8,   m_rd[0]);
    check("m8_out",  o8,    m_out[0]);
    check("m8_oe",   oe8,   m_dir[0]);
    check("m8_irq",  irq8,  m_irq[0]);
    check("m16_rd",  rd16,  m_rd[1]);
    check("m16_out", o16,   m_out[1]);
    check("m16_oe",  oe16,  m_dir[1]);
    check("m16_irq", irq16, m_irq[1]);
  endtask

  // ---------------- driver tasks ----------------
  task automatic bus(input logic s, input logic [4:0] a, input logic [3:0] d, input logic [31:0] w);
    sel = s; addr = a; dm = d; wd = w;
  endtask

  // Inputs are set at a negedge; the model follows the posedge and outputs
  // are compared at the following negedge.
  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    model_check();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rd8"},  rd8,  32'h0);
    check({tag, "_o8"},   o8,   32'h0);
    check({tag, "_oe8"},  oe8,  32'h0);
    check({tag, "_irq8"}, irq8, 32'h0);
    check({tag, "_rd16"}, rd16, 32'h0);
    check({tag, "_o16"},  o16,  32'h0);
    check({tag, "_oe16"}, oe16, 32'h0);
    check({tag, "_irq16"}, irq16, 32'h0);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        sel;
    logic [4:0]  addr;
    logic [3:0]  dm;
    logic [31:0] wd;
    logic [31:0] rd8;
    logic [7:0]  o8;
    logic [31:0] rd16;
    logic [15:0] o16;
    logic [15:0] oe16;
  } vec_t;

  vec_t tbl[$];

  initial begin
    rstn = 1'b0;
    bus(1'b0, 5'd0, 4'd0, 32'd0);
    pins = '0;
    model_reset();

    // Reset state while rstn is low.
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rstn = 1'b1;
    model_reset();

    // Offsets 0..7 read with assorted ignored low address bits.
    for (int i = 0; i < 8; i++)
      tbl.push_back('{1'b1, 5'(i * 4 + (i % 4)), 4'h0, 32'h0, 32'h0, 8'h00, 32'h0, 16'h0000, 16'h0000});
    tbl.push_back('{1'b1, 5'h00, 4'hF, 32'hFFFF_FFA5, 32'h0, 8'hA5, 32'h0, 16'hFFA5, 16'h0000}); // OUT
    tbl.push_back('{1'b1, 5'h0C, 4'h1, 32'h0000_000A, 32'h0, 8'hAF, 32'h0, 16'hFFAF, 16'h0000}); // SET
    tbl.push_back('{1'b1, 5'h10, 4'h1, 32'h0000_0001, 32'h0, 8'hAE, 32'h0, 16'hFFAE, 16'h0000}); // CLR
    tbl.push_back('{1'b1, 5'h14, 4'h1, 32'h0000_00F0, 32'h0, 8'h5E, 32'h0, 16'hFF5E, 16'h0000}); // TGL
    tbl.push_back('{1'b1, 5'h00, 4'h0, 32'h0, 32'h5E, 8'h5E, 32'hFF5E, 16'hFF5E, 16'h0000});      // read OUT
    tbl.push_back('{1'b1, 5'h0C, 4'h0, 32'h0, 32'h0, 8'h5E, 32'h0, 16'hFF5E, 16'h0000});          // read SET
    tbl.push_back('{1'b1, 5'h14, 4'h0, 32'h0, 32'h0, 8'h5E, 32'h0, 16'hFF5E, 16'h0000});          // read TGL
    tbl.push_back('{1'b1, 5'h04, 4'h2, 32'h0000_1234, 32'h0, 8'h5E, 32'h0, 16'hFF5E, 16'h1200});  // DIR lane 1
    tbl.push_back('{1'b1, 5'h04, 4'h0, 32'h0, 32'h0, 8'h5E, 32'h1200, 16'hFF5E, 16'h1200});       // read DIR
    tbl.push_back('{1'b1, 5'h00, 4'h1, 32'h0000_005E, 32'h0, 8'h5E, 32'h0, 16'hFF5E, 16'h1200});  // read-during-write
    tbl.push_back('{1'b0, 5'h00, 4'hF, 32'h0, 32'h0, 8'h5E, 32'h0, 16'hFF5E, 16'h1200});          // unselected write
    tbl.push_back('{1'b0, 5'h00, 4'h0, 32'h0, 32'h0, 8'h5E, 32'h0, 16'hFF5E, 16'h1200});          // unselected read
    tbl.push_back('{1'b1, 5'h00, 4'h0, 32'h0, 32'h5E, 8'h5E, 32'hFF5E, 16'hFF5E, 16'h1200});      // read OUT

    for (int i = 0; i < tbl.size(); i++) begin
      bus(tbl[i].sel, tbl[i].addr, tbl[i].dm, tbl[i].wd);
      cycle();
      check($sformatf("tbl%0d_rd8", i),  rd8,  tbl[i].rd8);
      check($sformatf("tbl%0d_o8", i),   o8,   tbl[i].o8);
      check($sformatf("tbl%0d_rd16", i), rd16, tbl[i].rd16);
      check($sformatf("tbl%0d_o16", i),  o16,  tbl[i].o16);
      check($sformatf("tbl%0d_oe16", i), oe16, tbl[i].oe16);
    end

    // ---- pin 3 rising edge -> IN, IS, irq, then W1C ----
    bus(1'b1, 5'h18, 4'h1, 32'h08);                 // IE = 0x08
    cycle();
    pins = 16'h0008;                                // rises during cycle t
    bus(1'b1, 5'h08, 4'h0, 32'h0);                  // read IN
    cycle(); check("in_t1", rd8, 32'h0);
    cycle(); check("in_t2", rd8, 32'h0);
    cycle(); check("in_t3", rd8, 32'h08);
    check("irq_t3", irq8, 1'b0);
    bus(1'b1, 5'h1C, 4'h0, 32'h0);                  // read IS
    cycle(); check("is_t4", rd8, IRQ_EN ? 32'h08 : 32'h0);
    check("irq_t4", irq8, IRQ_EN);
    bus(1'b1, 5'h1C, 4'h1, 32'h08);                 // W1C IS bit 3
    cycle(); check("irq_w1c_1", irq8, IRQ_EN);
    bus(1'b0, 5'h0, 4'h0, 32'h0);
    cycle(); check("irq_w1c_2", irq8, 1'b0);
    bus(1'b1, 5'h1C, 4'h0, 32'h0);
    cycle(); check("is_after_w1c", rd8, 32'h0);

    // ---- edge on bit 0 coinciding with W1C of IS[0]: set wins ----
    pins = 16'h0009;
    bus(1'b0, 5'h0, 4'h0, 32'h0);
    cycle(); cycle();
    bus(1'b1, 5'h1C, 4'h1, 32'h01);                 // W1C on the set edge
    cycle();
    bus(1'b1, 5'h1C, 4'h0, 32'h0);
    cycle(); check("is_set_wins", rd8, IRQ_EN ? 32'h01 : 32'h0);

    // ---- IE read-back (reads 0 without interrupt support) ----
    bus(1'b1, 5'h18, 4'hF, 32'hFFFF_FFFF);
    cycle();
    bus(1'b1, 5'h18, 4'h0, 32'h0);
    cycle(); check("ie_rd8", rd8, IRQ_EN ? 32'hFF : 32'h0);
    check("ie_rd16", rd16, IRQ_EN ? 32'hFFFF : 32'h0);

    // ---- randomized traffic against the model ----
    for (int i = 0; i < 600; i++) begin
      bus($urandom_range(0, 3) != 0, 5'($urandom_range(0, 31)),
          ($urandom_range(0, 1) != 0) ? 4'h0 : 4'($urandom_range(1, 15)), $urandom);
      if ($urandom_range(0, 3) == 0) pins = 16'($urandom);
      cycle();
    end

    // ---- reset asserted mid-write: write discarded, outputs clear at once ----
    bus(1'b1, 5'h00, 4'hF, 32'hFFFF_FFFF);
    #2 rstn = 1'b0;
    #1 check_all_zero("async_rst");
    @(posedge clk);
    @(negedge clk);
    bus(1'b0, 5'h0, 4'h0, 32'h0);
    rstn = 1'b1;
    model_reset();
    cycle();
    check("rst_discard_o8", o8, 32'h0);
    bus(1'b1, 5'h00, 4'h0, 32'h0);
    cycle();
    check("rst_discard_rd16", rd16, 32'h0);

    for (int i = 0; i < 200; i++) begin
      bus($urandom_range(0, 3) != 0, 5'($urandom_range(0, 31)),
          ($urandom_range(0, 1) != 0) ? 4'h0 : 4'($urandom_range(1, 15)), $urandom);
      if ($urandom_range(0, 2) == 0) pins = 16'($urandom);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
